// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic units: FSM state codes and
// single-bit full-subtractor equations.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } serial_state_t;

    function automatic logic fs_diff(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // Borrow when a < b, or when a == b and a borrow is already pending
    function automatic logic fs_borrow(input logic a, input logic b, input logic c);
        return (~a & b) | (~(a ^ b) & c);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full subtractor: {o_bout, o_diff} = i_x - i_y - i_bin.
module full_subtractor
    import serial_subtractor_pkg::*;
(
    input  logic i_x,
    input  logic i_y,
    input  logic i_bin,
    output logic o_diff,
    output logic o_bout
);

    assign o_diff = fs_diff(i_x, i_y, i_bin);
    assign o_bout = fs_borrow(i_x, i_y, i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock, with a
// start/busy/done handshake and registered results.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    serial_state_t    r_state;
    logic [WIDTH-1:0] r_xs;
    logic [WIDTH-1:0] r_ys;
    logic [WIDTH-2:0] r_ds;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic             w_d;
    logic             w_b;
    logic [WIDTH-2:0] w_ds_next;

    full_subtractor u_full_subtractor (
        .i_x    (r_xs[0]),
        .i_y    (r_ys[0]),
        .i_bin  (r_br),
        .o_diff (w_d),
        .o_bout (w_b)
    );

    // The difference shifter holds the WIDTH-1 low bits; the final bit joins at completion
    assign w_ds_next = (WIDTH-1)'({w_d, r_ds} >> 1);

    // FSM, operand/difference shifters, borrow flop, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_xs    <= '0;
            r_ys    <= '0;
            r_ds    <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_xs    <= x;
                        r_ys    <= y;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_xs  <= r_xs >> 1;
                    r_ys  <= r_ys >> 1;
                    r_br  <= w_b;
                    r_ds  <= w_ds_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_diff  <= {w_d, r_ds};
                        r_bout  <= w_b;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_done  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;

endmodule
